// File: rtl/input_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : input_sequencer                                                  |
// | Brief   : Latches a thickness triple, sweeps wavelength index 1..N_WL      |
// |           through the phase stage and streams the captured phases out.     |
// |           Optional macro SEQ_SWEEP_CNT_EN enables the sweep counter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module input_sequencer #(
    parameter int PD   = 12,
    parameter int P    = 22,
    parameter int N_WL = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PD+P-1:0]   in_d0,
    input  logic [PD+P-1:0]   in_d1,
    input  logic [PD+P-1:0]   in_d2,
    output logic [2:0]        cntr,
    output logic [PD+P-1:0]   d0,
    output logic [PD+P-1:0]   d1,
    output logic [PD+P-1:0]   d2,
    input  logic [8+P-1:0]    p0,
    input  logic [8+P-1:0]    p1,
    input  logic [8+P-1:0]    p2,
    input  logic [8+P-1:0]    p3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_wl,
    output logic              out_last,
    output logic [8+P-1:0]    out_p0,
    output logic [8+P-1:0]    out_p1,
    output logic [8+P-1:0]    out_p2,
    output logic [8+P-1:0]    out_p3,
    output logic [15:0]       sweep_cnt
);

    localparam int         c_DW      = PD + P;
    localparam int         c_PW      = 8 + P;
    localparam logic [2:0] c_LAST_WL = 3'(N_WL);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cntr_q, cntr_d;
    logic [c_DW-1:0]   d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_wl_q, out_wl_d;
    logic              out_last_q, out_last_d;
    logic [c_PW-1:0]   out_p0_q, out_p0_d, out_p1_q, out_p1_d;
    logic [c_PW-1:0]   out_p2_q, out_p2_d, out_p3_q, out_p3_d;

    logic w_capture;
    logic w_at_last;

    // A new result may enter the output register whenever it is empty or being drained.
    assign w_capture = (state_q == S_SWEEP) && (!out_valid_q || out_ready);
    assign w_at_last = (cntr_q == c_LAST_WL);

    always_comb begin
        state_d     = state_q;
        cntr_d      = cntr_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        out_valid_d = out_valid_q;
        out_wl_d    = out_wl_q;
        out_last_d  = out_last_q;
        out_p0_d    = out_p0_q;
        out_p1_d    = out_p1_q;
        out_p2_d    = out_p2_q;
        out_p3_d    = out_p3_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SWEEP;
                    cntr_d  = 3'd1;
                    d0_d    = in_d0;
                    d1_d    = in_d1;
                    d2_d    = in_d2;
                end
            end
            S_SWEEP: begin
                if (w_capture) begin
                    out_valid_d = 1'b1;
                    out_wl_d    = cntr_q;
                    out_last_d  = w_at_last;
                    out_p0_d    = p0;
                    out_p1_d    = p1;
                    out_p2_d    = p2;
                    out_p3_d    = p3;
                    if (w_at_last) begin
                        state_d = S_IDLE;
                        cntr_d  = 3'd0;
                    end else begin
                        cntr_d  = cntr_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cntr_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cntr_q      <= 3'd0;
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            out_valid_q <= 1'b0;
            out_wl_q    <= 3'd0;
            out_last_q  <= 1'b0;
            out_p0_q    <= '0;
            out_p1_q    <= '0;
            out_p2_q    <= '0;
            out_p3_q    <= '0;
        end else begin
            state_q     <= state_d;
            cntr_q      <= cntr_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            out_valid_q <= out_valid_d;
            out_wl_q    <= out_wl_d;
            out_last_q  <= out_last_d;
            out_p0_q    <= out_p0_d;
            out_p1_q    <= out_p1_d;
            out_p2_q    <= out_p2_d;
            out_p3_q    <= out_p3_d;
        end
    end

`ifdef SEQ_SWEEP_CNT_EN
    logic [15:0] sweep_cnt_q, sweep_cnt_d;

    always_comb begin
        sweep_cnt_d = sweep_cnt_q;
        if (w_capture && w_at_last && (sweep_cnt_q != 16'hFFFF)) begin
            sweep_cnt_d = sweep_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_cnt_q <= 16'h0000;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`else
    assign sweep_cnt = 16'h0000;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign cntr      = cntr_q;
    assign d0        = d0_q;
    assign d1        = d1_q;
    assign d2        = d2_q;
    assign out_valid = out_valid_q;
    assign out_wl    = out_wl_q;
    assign out_last  = out_last_q;
    assign out_p0    = out_p0_q;
    assign out_p1    = out_p1_q;
    assign out_p2    = out_p2_q;
    assign out_p3    = out_p3_q;

endmodule
`default_nettype wire
